// File: rtl/ram_responder.sv
// ram_responder
//
// Memory-side responder for the ALU RAM handshake. A single request
// (readReq or writeReq pulse) is accepted while idle. The request is answered
// with a one-cycle readAck or writeAck exactly LATENCY cycles after the cycle
// in which it was sampled. The data store is organised as 2**WORD_BITS 32-bit
// words and is addressed by byte address, so bits [1:0] are ignored. Any
// address with a bit set above the store range reads back OOR_DATA. Writes to
// such an address are dropped, but they are still acknowledged.
//
// Optional feature macro: RAM_RESPONDER_STATS_EN
//   When this macro is defined, readCount and writeCount are built as 16-bit
//   wrapping counters of completed reads and completed writes. When it is not
//   defined, both ports are tied to zero and the port list stays the same.
//
// Parameters
//   WORD_BITS  log2 of the store depth in 32-bit words (default 10 = 4 KB).
//   LATENCY    cycles from the request-sample cycle to the ack cycle. Legal
//              range is 1..15.
//   OOR_DATA   read data returned for out-of-range addresses.
//
// Ports
//   clk         clock; all state changes on the rising edge
//   reset       asynchronous, active-high reset
//   ramAddress  byte address from the initiator
//   ramOut      write data from the initiator
//   readReq     read request, one-cycle pulse
//   writeReq    write request, one-cycle pulse
//   ramIn       read data; valid in the readAck cycle and held until the next read ack
//   readAck     one-cycle pulse when a read completes
//   writeAck    one-cycle pulse when a write completes
//   protoError  sticky flag: a request was dropped or was illegal
//   readCount   completed reads (zero unless stats are enabled)
//   writeCount  completed writes (zero unless stats are enabled)

module ram_responder #(
    parameter int unsigned WORD_BITS = 10,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] OOR_DATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ramAddress,
    input  logic [31:0] ramOut,
    input  logic        readReq,
    input  logic        writeReq,
    output logic [31:0] ramIn,
    output logic        readAck,
    output logic        writeAck,
    output logic        protoError,
    output logic [15:0] readCount,
    output logic [15:0] writeCount
);

    localparam int unsigned DEPTH    = 1 << WORD_BITS;
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } StateT;

    StateT                state;
    StateT                nextState;
    logic [3:0]           latCount;
    logic [31:0]          addrLatch;
    logic [31:0]          dataLatch;
    logic                 opWriteLatch;
    logic [31:0]          store [DEPTH];

    logic                 anyReq;
    logic                 accept;
    logic                 enterAck;
    logic [31:0]          curAddr;
    logic [31:0]          curData;
    logic                 curWrite;
    logic [WORD_BITS-1:0] curIdx;
    logic                 curOor;
    logic                 unusedLowBits;

    // A request is taken only while idle. When both request lines are high,
    // the write is serviced and the read is dropped.
    assign anyReq = readReq | writeReq;
    assign accept = (state == IDLE) && anyReq;

    // The operation that is about to commit. When LATENCY is 1, the commit
    // happens on the same edge that samples the request. That edge comes
    // before the latches are loaded, so in IDLE the live inputs are used.
    assign curAddr  = (state == IDLE) ? ramAddress : addrLatch;
    assign curData  = (state == IDLE) ? ramOut     : dataLatch;
    assign curWrite = (state == IDLE) ? writeReq   : opWriteLatch;
    assign curIdx   = curAddr[WORD_BITS+1:2];
    assign curOor   = |curAddr[31:WORD_BITS+2];

    // The byte-lane bits take no part in word addressing.
    assign unusedLowBits = ^curAddr[1:0];

    // Next-state and ack decode. enterAck marks the edge on which read data
    // is captured and write data is committed. The acks are decoded from the
    // ACK state, so each ack lasts exactly one cycle.
    always_comb begin
        nextState = state;
        enterAck  = 1'b0;
        readAck   = 1'b0;
        writeAck  = 1'b0;
        unique case (state)
            IDLE: begin
                if (anyReq) begin
                    if (LATENCY == 1) begin
                        nextState = ACK;
                        enterAck  = 1'b1;
                    end else begin
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (latCount == 4'd1) begin
                    nextState = ACK;
                    enterAck  = 1'b1;
                end
            end
            ACK: begin
                readAck   = ~opWriteLatch;
                writeAck  = opWriteLatch;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register, request latches, latency counter, read data and the
    // sticky protocol error flag. A request that arrives while busy, in WAIT
    // or in ACK, leaves the in-flight operation alone and only raises
    // protoError.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            latCount     <= 4'd0;
            addrLatch    <= 32'd0;
            dataLatch    <= 32'd0;
            opWriteLatch <= 1'b0;
            ramIn        <= 32'd0;
            protoError   <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                addrLatch    <= ramAddress;
                dataLatch    <= ramOut;
                opWriteLatch <= writeReq;
                latCount     <= LAT_LOAD;
            end else if (state == WAIT) begin
                latCount <= latCount - 4'd1;
            end
            if (enterAck && !curWrite) begin
                ramIn <= curOor ? OOR_DATA : store[curIdx];
            end
            if ((accept && readReq && writeReq) || ((state != IDLE) && anyReq)) begin
                protoError <= 1'b1;
            end
        end
    end

    // The data store has no reset, so that it can map onto block RAM. The
    // reset term stops a write from committing if reset is asserted on its
    // commit edge. That case arises when LATENCY is 1 and a write request
    // coincides with reset.
    always_ff @(posedge clk) begin
        if (enterAck && curWrite && !curOor && !reset) begin
            store[curIdx] <= curData;
        end
    end

`ifdef RAM_RESPONDER_STATS_EN
    // Completed-operation counters. They step on each ack cycle and wrap
    // naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readCount  <= 16'd0;
            writeCount <= 16'd0;
        end else begin
            if (readAck) begin
                readCount <= readCount + 16'd1;
            end
            if (writeAck) begin
                writeCount <= writeCount + 16'd1;
            end
        end
    end
`else
    // No statistics in this build.
    assign readCount  = 16'd0;
    assign writeCount = 16'd0;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder
//
// Drives three ram_responder instances with LATENCY 1, 2 and 7 from the same
// request stream. Each lane keeps its own reference model: a word array for
// the store, a busy-until cycle number, and a queue of expected responses
// tagged with their due cycle. Every negative clock edge, each lane compares
// the acks, ramIn, protoError and the counters against that model.

module tb_ram_responder;

    localparam int NLANES = 3;
    localparam int GAP    = 9;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [31:0] ramAddress = 32'd0;
    logic [31:0] ramOut     = 32'd0;
    logic        readReq    = 1'b0;
    logic        writeReq   = 1'b0;

    logic [31:0] ramInW      [NLANES];
    logic        readAckW    [NLANES];
    logic        writeAckW   [NLANES];
    logic        protoErrorW [NLANES];
    logic [15:0] readCountW  [NLANES];
    logic [15:0] writeCountW [NLANES];

    int checks   = 0;
    int errors   = 0;
    int cycleNum = 0;

    typedef struct {
        int          due;
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] readVal;
    } ExpT;

    // Free-running clock and cycle index used to time expected acks.
    always #5 clk = ~clk;

    always @(posedge clk) cycleNum <= cycleNum + 1;

    // One comparison against the reference model.
    task automatic checkOutput(input string name, input int lane,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s lane%0d: got %h, expected %h", name, lane, actual, expected);
        end
    endtask

    // Per-lane DUT plus its own model and monitor.
    for (genvar g = 0; g < NLANES; g++) begin : lane
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 7;

        ram_responder #(
            .WORD_BITS(10),
            .LATENCY(L),
            .OOR_DATA(32'hDEADBEEF)
        ) dut (
            .clk(clk),
            .reset(reset),
            .ramAddress(ramAddress),
            .ramOut(ramOut),
            .readReq(readReq),
            .writeReq(writeReq),
            .ramIn(ramInW[g]),
            .readAck(readAckW[g]),
            .writeAck(writeAckW[g]),
            .protoError(protoErrorW[g]),
            .readCount(readCountW[g]),
            .writeCount(writeCountW[g])
        );

        ExpT         expQ[$];
        logic [31:0] refMem [1024];
        logic [31:0] lastRead   = 32'd0;
        bit          protoExp   = 1'b0;
        int          busyUntil  = -1;
        int          readsDone  = 0;
        int          writesDone = 0;

        always @(negedge clk) begin
            ExpT e;
            bit  ackDue;
            e = '{0, 1'b0, 32'd0, 32'd0, 32'd0};
            if (reset) begin
                expQ.delete();
                lastRead   = 32'd0;
                protoExp   = 1'b0;
                busyUntil  = -1;
                readsDone  = 0;
                writesDone = 0;
            end
`ifdef RAM_RESPONDER_STATS_EN
            checkOutput("readCount", g, {16'd0, readCountW[g]}, 32'(readsDone & 16'hFFFF));
            checkOutput("writeCount", g, {16'd0, writeCountW[g]}, 32'(writesDone & 16'hFFFF));
`else
            checkOutput("readCount", g, {16'd0, readCountW[g]}, 32'd0);
            checkOutput("writeCount", g, {16'd0, writeCountW[g]}, 32'd0);
`endif
            ackDue = !reset && (expQ.size() > 0) && (expQ[0].due == cycleNum);
            if (ackDue) begin
                e = expQ.pop_front();
                if (e.isWrite) begin
                    writesDone++;
                end else begin
                    lastRead = e.readVal;
                    readsDone++;
                end
            end
            checkOutput("readAck", g, {31'd0, readAckW[g]}, {31'd0, ackDue && !e.isWrite});
            checkOutput("writeAck", g, {31'd0, writeAckW[g]}, {31'd0, ackDue && e.isWrite});
            checkOutput("ramIn", g, ramInW[g], lastRead);
            checkOutput("protoError", g, {31'd0, protoErrorW[g]}, {31'd0, protoExp});

            if (!reset) begin
                if (readReq || writeReq) begin
                    if (cycleNum <= busyUntil) begin
                        protoExp = 1'b1;
                    end else begin
                        if (readReq && writeReq) protoExp = 1'b1;
                        busyUntil = cycleNum + L;
                        expQ.push_back('{cycleNum + L, writeReq, ramAddress, ramOut, 32'd0});
                    end
                end
                if ((expQ.size() > 0) && (expQ[0].due == cycleNum + 1)) begin
                    if (expQ[0].isWrite) begin
                        if (expQ[0].addr < 32'h1000) refMem[expQ[0].addr / 4] = expQ[0].data;
                    end else begin
                        expQ[0].readVal = (expQ[0].addr < 32'h1000) ? refMem[expQ[0].addr / 4]
                                                                    : 32'hDEADBEEF;
                    end
                end
            end
        end
    end

    // Drive one request for one cycle. Tasks start and finish 1 time unit
    // after a rising edge.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] data);
        ramAddress = addr;
        ramOut     = data;
        readReq    = rd;
        writeReq   = wr;
        @(posedge clk);
        #1;
        readReq  = 1'b0;
        writeReq = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkAllRamIn(input string name, input logic [31:0] expected);
        for (int k = 0; k < NLANES; k++) checkOutput(name, k, ramInW[k], expected);
    endtask

    task automatic checkAllProto(input string name, input logic expected);
        for (int k = 0; k < NLANES; k++) checkOutput(name, k, {31'd0, protoErrorW[k]}, {31'd0, expected});
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        for (int w = 0; w < 64; w++) begin
            applyStimulus(1'b0, 1'b1, 32'(w * 4), $urandom);
            idle(GAP);
        end

        applyStimulus(1'b0, 1'b1, 32'h40, 32'h12345678); idle(GAP);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0);        idle(GAP);
        checkAllRamIn("writeRead", 32'h12345678);

        applyStimulus(1'b0, 1'b1, 32'h104, 32'hCAFEF00D); idle(GAP);
        applyStimulus(1'b1, 1'b0, 32'h107, 32'd0);        idle(GAP);
        checkAllRamIn("alignment", 32'hCAFEF00D);

        applyStimulus(1'b1, 1'b0, 32'h1000, 32'd0); idle(GAP);
        checkAllRamIn("oorRead", 32'hDEADBEEF);

        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000AAAA);    idle(GAP);
        applyStimulus(1'b0, 1'b1, 32'h1000, 32'hBADBAD00); idle(GAP);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'd0);           idle(GAP);
        checkAllRamIn("oorWriteDiscarded", 32'h0000AAAA);
        checkAllProto("protoClean", 1'b0);

        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0);
        idle(GAP);
        checkAllProto("busyRequest", 1'b1);
        checkAllRamIn("busyRead", 32'h12345678);

        pulseReset();
        idle(2);
        checkAllProto("protoAfterReset", 1'b0);
        checkAllRamIn("ramInAfterReset", 32'd0);

        applyStimulus(1'b1, 1'b1, 32'h44, 32'h77778888); idle(GAP);
        checkAllProto("collision", 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h44, 32'd0); idle(GAP);
        checkAllRamIn("collisionWrite", 32'h77778888);

        applyStimulus(1'b0, 1'b1, 32'h80, 32'h11112222); idle(GAP);
        ramAddress = 32'h80;
        ramOut     = 32'h55AA55AA;
        writeReq   = 1'b1;
        @(posedge clk);
        #1;
        writeReq = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        applyStimulus(1'b1, 1'b0, 32'h80, 32'd0); idle(GAP);
        for (int k = 0; k < NLANES; k++) begin
            checkOutput("resetAbortWrite", k, ramInW[k], (k == 0) ? 32'h55AA55AA : 32'h11112222);
        end

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h1000;
            else a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 4)      applyStimulus(1'b0, 1'b1, a, $urandom);
            else if (r < 9) applyStimulus(1'b1, 1'b0, a, $urandom);
            else            applyStimulus(1'b1, 1'b1, a, $urandom);
            if ($urandom_range(0, 5) == 0) applyStimulus(1'b1, 1'b0, a, 32'd0);
            idle(GAP + $urandom_range(0, 2));
        end

        idle(12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
